// File: rtl/photonic_channel_arbiter_if.sv
// Request/grant bundle between the photonic nodes and the arbiter.
// Nodes drive max_node/req/req_len; the arbiter answers with grant and control.
interface photonic_channel_arbiter_if #(
  parameter int NODES = 4
);
  logic [15:0]         max_node;
  logic [NODES-1:0]    req;
  logic [16*NODES-1:0] req_len;
  logic [NODES-1:0]    grant;
  logic [31:0]         control_tx_packet;
  logic                control_valid;
  logic                tx_enable;
  logic [15:0]         current_node;
  logic                busy;

  modport master (
    output max_node,
    output req,
    output req_len,
    input  grant,
    input  control_tx_packet,
    input  control_valid,
    input  tx_enable,
    input  current_node,
    input  busy
  );

  modport slave (
    input  max_node,
    input  req,
    input  req_len,
    output grant,
    output control_tx_packet,
    output control_valid,
    output tx_enable,
    output current_node,
    output busy
  );
endinterface

// File: rtl/photonic_channel_arbiter.sv
// Round-robin owner of the shared photonic waveguide.
// Ports: clk, rst (async high), bus (slave side of the request/grant bundle).
module photonic_channel_arbiter #(
  parameter int NODES        = 4,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  photonic_channel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ANNOUNCE,
    BURST,
    GUARD
  } state_t;

  localparam logic [4:0]  NODES_W   = 5'(NODES);
  localparam logic [15:0] GUARD_LEN = 16'(GUARD_CYCLES);

  state_t      state_q, state_d;
  logic [4:0]  rr_q, rr_d;
  logic [4:0]  sel_q, sel_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;

  logic [4:0]  eff;
  logic [4:0]  start;
  logic        lo_hit, hi_hit;
  logic [4:0]  lo_id, hi_id, hit_id;
  logic [15:0] lo_len, hi_len, hit_len;
  logic [4:0]  rr_nxt;

  logic [NODES-1:0] grant_d, grant_q;
  logic [31:0]      pkt_d, pkt_q;
  logic             cv_d, cv_q;
  logic             tx_d, tx_q;
  logic [15:0]      cur_d, cur_q;
  logic             busy_d, busy_q;

  always_comb begin
    if (bus.max_node > 16'(NODES)) begin
      eff = NODES_W;
    end else begin
      eff = bus.max_node[4:0];
    end
  end

  // A pointer left beyond a shrunken range wraps into it.
  assign start = (eff == 5'd0) ? 5'd0 : rr_q % eff;

  // Rotating search as two priority scans: lowest eligible at or
  // above start wins, otherwise the lowest eligible overall.
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_id  = '0;
    hi_id  = '0;
    lo_len = '0;
    hi_len = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (bus.req[i] && (5'(i) < eff) &&
          (bus.req_len[16*i +: 16] != 16'd0)) begin
        lo_hit = 1'b1;
        lo_id  = 5'(i);
        lo_len = bus.req_len[16*i +: 16];
        if (5'(i) >= start) begin
          hi_hit = 1'b1;
          hi_id  = 5'(i);
          hi_len = bus.req_len[16*i +: 16];
        end
      end
    end
  end

  assign hit_id  = hi_hit ? hi_id : lo_id;
  assign hit_len = hi_hit ? hi_len : lo_len;
  // Advance with the same clamp that picked the node.
  assign rr_nxt  = (hit_id + 5'd1 >= eff) ? 5'd0 : hit_id + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      pkt_q   <= '0;
      cv_q    <= 1'b0;
      tx_q    <= 1'b0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      pkt_q   <= pkt_d;
      cv_q    <= cv_d;
      tx_q    <= tx_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lo_hit) begin
          state_d = ANNOUNCE;
          sel_d   = hit_id;
          len_d   = hit_len;
          rr_d    = rr_nxt;
        end
      end
      ANNOUNCE: begin
        state_d = BURST;
        cnt_d   = len_q;
      end
      BURST: begin
        // len is never 0 here, so the counter stops at 1.
        if (cnt_q == 16'd1) begin
          if (GUARD_CYCLES > 0) begin
            state_d = GUARD;
            cnt_d   = GUARD_LEN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GUARD: begin
        if (cnt_q <= 16'd1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    grant_d = '0;
    pkt_d   = '0;
    cv_d    = 1'b0;
    tx_d    = 1'b0;
    cur_d   = '0;
    busy_d  = 1'b0;
    unique case (state_d)
      ANNOUNCE: begin
        cv_d   = 1'b1;
        pkt_d  = {11'd0, sel_d, len_d};
        cur_d  = {11'd0, sel_d};
        busy_d = 1'b1;
        for (int i = 0; i < NODES; i++) begin
          grant_d[i] = (sel_d == 5'(i));
        end
      end
      BURST: begin
        tx_d   = 1'b1;
        cur_d  = {11'd0, sel_d};
        busy_d = 1'b1;
        for (int i = 0; i < NODES; i++) begin
          grant_d[i] = (sel_d == 5'(i));
        end
      end
      GUARD: begin
        busy_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.grant             = grant_q;
  assign bus.control_tx_packet = pkt_q;
  assign bus.control_valid     = cv_q;
  assign bus.tx_enable         = tx_q;
  assign bus.current_node      = cur_q;
  assign bus.busy              = busy_q;

endmodule
